core_rst_seq: RTL



---
 rtl/core_rst_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/core_rst_seq.sv
// core_rst_seq: releases present and software-enabled SoC cores from reset
// one at a time, with a fixed stagger between releases. It is controlled
// through a four-register CSR page: CTRL, MASK, STATUS and CAPS.
// Optional feature macro: CORE_RST_SEQ_IRQ_EN adds an irq output and the
// CTRL.IRQEN bit.
// dbg_state exposes the FSM state: 0 IDLE, 1 CHECK, 2 WAIT, 3 DONE.
module core_rst_seq #(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         NCORES   = 12,
    parameter int         STAGGER  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [13:0]       csr_a,
    input  logic              csr_we,
    input  logic [31:0]       csr_di,
    output logic [31:0]       csr_do,
    input  logic [31:0]       capabilities,
    output logic [NCORES-1:0] core_rst_n,
    output logic              seq_done,
`ifdef CORE_RST_SEQ_IRQ_EN
    output logic              irq,
`endif
    output logic [1:0]        dbg_state
);

    // A STAGGER of 1 would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NCORES-1:0] rst_q, rst_d;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irqen_q, irqen_d;
    logic              irq_q, irq_d;

    logic              page_sel;
    logic              wr_ctrl;
    logic              wr_mask;
    logic              start;
    logic              abort;
    logic [NCORES-1:0] eligible;
    logic              unused_bits;

    assign page_sel = (csr_a[13:10] == csr_addr);
    assign wr_ctrl  = page_sel && csr_we && (csr_a[1:0] == 2'd0);
    assign wr_mask  = page_sel && csr_we && (csr_a[1:0] == 2'd1);
    assign start    = wr_ctrl && csr_di[0];
    assign abort    = wr_ctrl && csr_di[1];
    // Sampled live, so changes only matter for indices not yet checked.
    assign eligible = capabilities[NCORES-1:0] & mask_q;

    assign unused_bits = ^{csr_a[9:2], csr_di};

    // Sequencer next state. ABORT wins over everything, including START.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        if (abort) begin
            rst_d   = '0;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // Released cores stay released across a restart.
                    if (start) begin
                        idx_d   = 4'd0;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (idx_q == 4'(NCORES)) begin
                        state_d = S_DONE;
                    end else if (eligible[idx_q]) begin
                        rst_d[idx_q] = 1'b1;
                        cnt_d        = CNT_W'(STAGGER - 1);
                        state_d      = S_WAIT;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_CHECK;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Software-visible control registers.
    always_comb begin
        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = csr_di[NCORES-1:0];
        end
        irqen_d = 1'b0;
`ifdef CORE_RST_SEQ_IRQ_EN
        irqen_d = irqen_q;
        if (wr_ctrl) begin
            irqen_d = csr_di[2];
        end
`endif
        irq_d = irqen_q && (state_d == S_DONE) && (state_q != S_DONE);
    end

    // Registered read mux; off-page reads return zero.
    always_comb begin
        rdata_d = '0;
        if (page_sel) begin
            case (csr_a[1:0])
                2'd0: rdata_d[2] = irqen_q;
                2'd1: rdata_d[NCORES-1:0] = mask_q;
                2'd2: begin
                    rdata_d[0]           = (state_q == S_CHECK) || (state_q == S_WAIT);
                    rdata_d[1]           = (state_q == S_DONE);
                    rdata_d[4 +: NCORES] = rst_q;
                end
                default: rdata_d = capabilities;
            endcase
        end
    end

    // State and register update; reset forces every register to its idle value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            rst_q   <= '0;
            mask_q  <= '1;
            rdata_q <= '0;
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign csr_do     = rdata_q;
    assign core_rst_n = rst_q;
    assign seq_done   = (state_q == S_DONE);
    assign dbg_state  = state_q;
`ifdef CORE_RST_SEQ_IRQ_EN
    assign irq        = irq_q;
`endif

endmodule
